// File: rtl/multibyte_add_sequencer.sv
// Byte-serial add/subtract sequencer driving one external 8-bit adder.
// LSB byte first, carry chained through a register between bytes.
module multibyte_add_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  sub,
    input  logic [8*NBYTES-1:0]   op_a,
    input  logic [8*NBYTES-1:0]   op_b,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  cout,
    output logic                  ovf,
    output logic [7:0]            add_a,
    output logic [7:0]            add_b,
    output logic                  add_c0,
    input  logic [7:0]            add_f,
    input  logic                  add_c8
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 2) ? $clog2(NBYTES) : 1;

    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic [W-1:0]  a_r;
    logic [W-1:0]  bx_r;
    logic          carry;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Present the current byte slice to the adder only while running
    always_comb begin
        add_a  = 8'd0;
        add_b  = 8'd0;
        add_c0 = 1'b0;
        if (state == RUN) begin
            add_a  = a_r[{idx, 3'b000} +: 8];
            add_b  = bx_r[{idx, 3'b000} +: 8];
            add_c0 = carry;
        end
    end

    // FSM, operand capture, byte write-back and final flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            a_r    <= '0;
            bx_r   <= '0;
            carry  <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= op_a;
                        bx_r  <= sub ? ~op_b : op_b;
                        carry <= sub;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    result[{idx, 3'b000} +: 8] <= add_f;
                    carry <= add_c8;
                    idx   <= idx + 1'b1;
                    if (idx == LAST) begin
                        cout  <= add_c8;
                        ovf   <= (a_r[W-1] == bx_r[W-1]) &&
                                 (add_f[7] != a_r[W-1]);
                        idx   <= '0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// Scoreboard bench for multibyte_add_sequencer with a behavioural
// 8-bit adder wired to the add_* port group.
module tb_multibyte_add_sequencer;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic [7:0]   add_a;
    logic [7:0]   add_b;
    logic         add_c0;
    logic [7:0]   add_f;
    logic         add_c8;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         v;
        int           cyc;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   total  = 0;
    int   bad    = 0;
    int   ndone  = 0;
    int   npush  = 0;

    multibyte_add_sequencer #(.NBYTES(NB)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sub    (sub),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf),
        .add_a  (add_a),
        .add_b  (add_b),
        .add_c0 (add_c0),
        .add_f  (add_f),
        .add_c8 (add_c8)
    );

    assign {add_c8, add_f} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_c0};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare whenever done is presented
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            ndone++;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done at cyc %0d want none",
                         cyc);
            end else begin
                e = q.pop_front();
                chk("result", 64'(result), 64'(e.res));
                chk("cout", 64'(cout), 64'(e.c));
                chk("ovf", 64'(ovf), 64'(e.v));
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL wait_idle: got busy=%0b want 0", busy);
        end
    endtask

    task automatic push(input logic [W-1:0] r, input logic c,
                        input logic v, input int acc);
        exp_t e;
        e.res = r;
        e.c   = c;
        e.v   = v;
        e.cyc = acc + NB;
        q.push_back(e);
        npush++;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic [W-1:0] r,
                          input logic c, input logic v);
        wait_idle();
        op_a  = a;
        op_b  = b;
        sub   = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        push(r, c, v, cyc);
    endtask

    initial begin
        int acc;
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_add", 64'({add_a, add_b, add_c0}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(32'h11111111, 32'h11111111, 1'b0, 32'h22222222, 1'b0, 1'b0);
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);

        // First byte of a subtract: inverted B and carry-in of 1
        wait_idle();
        op_a  = 32'h00000000;
        op_b  = 32'h00000001;
        sub   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        push(32'hFFFFFFFF, 1'b0, 1'b0, cyc);
        chk("sub_add_a", 64'(add_a), 64'h00);
        chk("sub_add_b", 64'(add_b), 64'hFE);
        chk("sub_add_c0", 64'(add_c0), 64'd1);
        chk("run_busy", 64'(busy), 64'd1);

        run_op(32'h33333333, 32'h11111111, 1'b1, 32'h22222222, 1'b1, 1'b0);
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
        run_op(32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);

        wait_idle();
        chk("idle_add", 64'({add_a, add_b, add_c0}), 64'd0);
        chk("hold_result", 64'(result), 64'h7FFFFFFF);

        // start held through RUN and DONE is dropped; next IDLE start taken
        op_a  = 32'h01020304;
        op_b  = 32'h10203040;
        sub   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        push(32'h11223344, 1'b0, 1'b0, cyc);
        op_a = 32'hDEADBEEF;
        op_b = 32'h12345678;
        sub  = 1'b1;
        repeat (NB + 1) @(posedge clk);
        #1;
        chk("idle_after_done", 64'(busy), 64'd0);
        op_a = 32'h00000005;
        op_b = 32'h00000003;
        sub  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        push(32'h00000002, 1'b1, 1'b0, cyc);

        // Reset while byte 2 is being processed
        wait_idle();
        op_a  = 32'hAAAAAAAA;
        op_b  = 32'h11111111;
        sub   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_result", 64'(result), 64'd0);
        chk("abort_cout", 64'(cout), 64'd0);
        repeat (8) @(posedge clk);
        #1;

        run_op(32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0);

        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("queue_drained", 64'(q.size()), 64'd0);
        chk("done_count", 64'(ndone), 64'(npush));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
